// File: rtl/regfile_pkg.sv
// Shared types and limits for the multiport register file.
// Build option: REGFILE_BYPASS_EN enables write-first read forwarding.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

  localparam int RF_MAX_RD = 4;

endpackage

// File: rtl/regfile_multiport_word.sv
// One register word: synchronous reset, load enable, clear-to-zero.
// Used once per non-hardwired register by regfile_multiport.
module rf_word_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d, or zero while the clear engine owns the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= clear ? '0 : d;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// DEPTH x WIDTH register file, NUM_RD async reads, one sync write, bulk clear.
// Build option: REGFILE_BYPASS_EN forwards wr_data to matching read ports.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_IDX = 31,
  parameter int HAS_ZERO = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    clear_req,
  output logic                    busy
);

  rf_state_e        state;
  rf_state_e        state_n;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cnt_n;
  logic             is_zero;
  logic             wr_ok;
  logic [WIDTH-1:0] words [DEPTH];

  assign busy    = (state == RF_CLEAR);
  assign is_zero = (HAS_ZERO != 0) && (wr_addr == AW'(ZERO_IDX));
  assign wr_ok   = wr_en && !busy && !is_zero;

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    if ((HAS_ZERO != 0) && (k == ZERO_IDX)) begin : g_zero
      assign words[k] = '0;
    end else begin : g_reg
      logic load;
      assign load = busy ? (cnt == AW'(k))
                         : (wr_ok && (wr_addr == AW'(k)));
      rf_word_reg #(
        .WIDTH (WIDTH)
      ) u_word (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .clear (busy),
        .d     (wr_data),
        .q     (words[k])
      );
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign rd_data[i*WIDTH +: WIDTH] =
      (wr_ok && (ra == wr_addr)) ? wr_data : words[ra];
`else
    assign rd_data[i*WIDTH +: WIDTH] = words[ra];
`endif
  end

  // Clear FSM state and sweep counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RF_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: start on clear_req, sweep every word once, then idle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      RF_IDLE: begin
        if (clear_req) begin
          state_n = RF_CLEAR;
          cnt_n   = '0;
        end
      end
      RF_CLEAR: begin
        cnt_n = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) begin
          state_n = RF_IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport.
// Honours REGFILE_BYPASS_EN when computing same-cycle read expectations.
module tb_regfile_multiport;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DBEF = 64'hDEAD_BEEF_0123_4567;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [127:0] rd_data_nz;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         clear_req;
  logic         busy;
  logic         busy_nz;
  logic [4:0]   ra0;
  logic [4:0]   ra1;

  int checks = 0;
  int errors = 0;

  assign rd_addr = {ra1, ra0};

  always #50 clk = ~clk;

  regfile_multiport dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear_req (clear_req),
    .busy      (busy)
  );

  regfile_multiport #(
    .HAS_ZERO (0)
  ) dut_nz (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data_nz),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear_req (clear_req),
    .busy      (busy_nz)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [63:0] e0;
    logic [63:0] e1;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd(input vec_t v, input logic [4:0] ra,
                                         input logic [63:0] old);
`ifdef REGFILE_BYPASS_EN
    if (v.we && v.wa != 5'd31 && ra == v.wa) return v.wd;
`endif
    return old;
  endfunction

  initial begin
    vecs[0] = '{1'b1, 5'd5,  DBEF,      5'd5,  5'd5,  64'h0,     64'h0};
    vecs[1] = '{1'b0, 5'd0,  64'h0,     5'd5,  5'd6,  DBEF,      64'h0};
    vecs[2] = '{1'b1, 5'd31, ONES,      5'd31, 5'd5,  64'h0,     DBEF};
    vecs[3] = '{1'b0, 5'd0,  64'h0,     5'd31, 5'd5,  64'h0,     DBEF};
    vecs[4] = '{1'b1, 5'd3,  64'h1234,  5'd3,  5'd3,  64'h0,     64'h0};
    vecs[5] = '{1'b0, 5'd0,  64'h0,     5'd3,  5'd0,  64'h1234,  64'h0};
    vecs[6] = '{1'b1, 5'd0,  64'hA5A5,  5'd0,  5'd3,  64'h0,     64'h1234};
    vecs[7] = '{1'b0, 5'd0,  64'h0,     5'd0,  5'd31, 64'hA5A5,  64'h0};

    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd7; wr_data = ONES;
    clear_req = 1'b0; ra0 = 5'd7; ra1 = 5'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0; wr_en = 1'b0;
    #1;
    chk("reset_rd0", rd_data[63:0], 64'h0);
    chk("reset_rd1", rd_data[127:64], 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      ra0 = vecs[i].r0; ra1 = vecs[i].r1;
      #1;
      chk($sformatf("vec%0d_rd0", i), rd_data[63:0],
          exp_rd(vecs[i], vecs[i].r0, vecs[i].e0));
      chk($sformatf("vec%0d_rd1", i), rd_data[127:64],
          exp_rd(vecs[i], vecs[i].r1, vecs[i].e1));
    end

    @(negedge clk);
    wr_en = 1'b0; ra0 = 5'd31; ra1 = 5'd31;
    #1;
    chk("xzr_reads_zero", rd_data[63:0], 64'h0);
    chk("nz_reg31_ones", rd_data_nz[63:0], ONES);

    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'(k); wr_data = 64'(k);
    end
    @(negedge clk);
    wr_en = 1'b0; clear_req = 1'b1; ra0 = 5'd17; ra1 = 5'd31;
    #1;
    chk("fill_reg17", rd_data[63:0], 64'd17);
    chk("nz_fill_reg31", rd_data_nz[127:64], 64'd31);

    for (int j = 0; j < 34; j++) begin
      @(negedge clk);
      clear_req = (j == 20);
      wr_en = (j == 5); wr_addr = 5'd2; wr_data = 64'hFF;
      ra0 = (j >= 1) ? 5'(j - 1) : 5'd0;
      ra1 = 5'(j);
      #1;
      chk($sformatf("clr_busy_%0d", j), {63'h0, busy}, {63'h0, j < 32});
      if (j >= 1 && j <= 32)
        chk($sformatf("clr_done_%0d", j - 1), rd_data[63:0], 64'h0);
      if (j <= 30)
        chk($sformatf("clr_pend_%0d", j), rd_data[127:64], 64'(j));
    end
    @(negedge clk);
    wr_en = 1'b0; clear_req = 1'b0; ra0 = 5'd2; ra1 = 5'd31;
    #1;
    chk("clr_write_dropped", rd_data[63:0], 64'h0);
    chk("nz_clr_reg31", rd_data_nz[127:64], 64'h0);
    chk("clr_busy_idle", {63'h0, busy}, 64'h0);

    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'h20;
    @(negedge clk);
    wr_addr = 5'd5; wr_data = 64'h55;
    @(negedge clk);
    wr_en = 1'b0; clear_req = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      clear_req = 1'b0;
      reset = (j == 10);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a);
      #1;
      chk($sformatf("midrst_reg%0d", a), rd_data[63:0], 64'h0);
    end

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'h11;
    @(negedge clk);
    wr_addr = 5'd1; wr_data = 64'h22;
    @(negedge clk);
    wr_en = 1'b0; clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0; ra0 = 5'd0; ra1 = 5'd1;
    #1;
    chk("restart_busy", {63'h0, busy}, 64'h1);
    chk("restart_c0_r0", rd_data[63:0], 64'h11);
    chk("restart_c0_r1", rd_data[127:64], 64'h22);
    @(negedge clk);
    #1;
    chk("restart_c1_r0", rd_data[63:0], 64'h0);
    chk("restart_c1_r1", rd_data[127:64], 64'h22);
    @(negedge clk);
    #1;
    chk("restart_c2_r1", rd_data[127:64], 64'h0);
    repeat (31) @(negedge clk);
    #1;
    chk("restart_end_busy", {63'h0, busy}, 64'h0);
    chk("nz_end_busy", {63'h0, busy_nz}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
